// File: rtl/bakery_pkg.sv
// Shared types and helpers for the bakery model and its fair scheduler.
package bakery_pkg;

    typedef enum logic [1:0] {S_IDLE, S_FREE, S_FORCE} sched_state;

    localparam int unsigned SELMSB_DEF = 1;
    localparam int unsigned HIPROC_DEF = 2;

    // First set bit of vec[n-1:0], scanning upward from start with wrap; -1 if none.
    // Supports up to 32 processes.
    function automatic int first_set_wrap(input logic [31:0] vec, input int n, input int start);
        int hit;
        int idx;
        hit = -1;
        for (int k = 0; k < 32; k++) begin
            idx = (start + k) % n;
            if (k < n && hit < 0 && vec[idx]) begin
                hit = idx;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/bakery_fair_sched_if.sv
// Scheduler <-> bakery model bundle: requests and preferences in, registered grant out.
interface bakery_fair_sched_if
    import bakery_pkg::*;
#(
    parameter int unsigned SELMSB = SELMSB_DEF,
    parameter int unsigned HIPROC = HIPROC_DEF
);
    logic [HIPROC:0] req;
    logic [SELMSB:0] choice;
    logic            want_pause;
    logic [SELMSB:0] select;
    logic            pause;
    logic            grant_valid;
    logic            forced;
    logic [HIPROC:0] fair;

    modport master (
        output req, choice, want_pause,
        input  select, pause, grant_valid, forced, fair
    );

    modport slave (
        input  req, choice, want_pause,
        output select, pause, grant_valid, forced, fair
    );
endinterface

// File: rtl/bakery_rr_pick.sv
// Combinational wrap-around picker: first eligible requester after i_ptr.
module bakery_rr_pick
    import bakery_pkg::*;
#(
    parameter int unsigned SELMSB = SELMSB_DEF,
    parameter int unsigned HIPROC = HIPROC_DEF
) (
    input  logic [HIPROC:0] i_req,
    input  logic [SELMSB:0] i_ptr,
    input  logic [HIPROC:0] i_mask,
    output logic [SELMSB:0] o_idx,
    output logic            o_valid
);
    localparam int          NPROC = int'(HIPROC) + 1;
    localparam int unsigned SELW  = SELMSB + 1;

    logic [31:0] w_vec;
    int          w_hit;

    always_comb begin
        w_vec           = '0;
        w_vec[HIPROC:0] = i_req & i_mask;
        w_hit           = first_set_wrap(w_vec, NPROC, (int'(i_ptr) + 1) % NPROC);
        o_valid         = (w_hit >= 0);
        o_idx           = o_valid ? SELW'(w_hit) : '0;
    end
endmodule

// File: rtl/bakery_fair_sched.sv
// Bounded-fair scheduler: honours the free choice unless a requester is starving
// or a process has been paused too long.
module bakery_fair_sched
    import bakery_pkg::*;
#(
    parameter int unsigned SELMSB    = SELMSB_DEF,
    parameter int unsigned HIPROC    = HIPROC_DEF,
    parameter int unsigned BOUND     = 3,
    parameter int unsigned PAUSE_MAX = 2,
    parameter int unsigned CNTW      = 2
) (
    input logic               clock,
    input logic               reset,
    bakery_fair_sched_if.slave bus
);
    localparam int unsigned     SELW      = SELMSB + 1;
    localparam int              NPROC     = int'(HIPROC) + 1;
    localparam logic [CNTW-1:0] CNT_BOUND = CNTW'(BOUND);
    localparam logic [CNTW-1:0] CNT_PMAX  = CNTW'(PAUSE_MAX);
    localparam logic [SELMSB:0] LOW_PTR   = SELW'(HIPROC);

    sched_state      r_state;
    logic [CNTW-1:0] r_wait_cnt  [NPROC];
    logic [CNTW-1:0] r_pause_cnt [NPROC];
    logic [SELMSB:0] r_rr_ptr;
    logic [SELMSB:0] r_select;
    logic            r_pause;
    logic            r_grant_valid;
    logic            r_forced;
    logic [HIPROC:0] r_fair;

    logic [HIPROC:0] w_starved;
    logic [SELMSB:0] w_st_idx;
    logic            w_st_valid;
    logic [SELMSB:0] w_rr_idx;
    logic            w_rr_valid;
    logic            w_choice_ok;
    logic [SELMSB:0] w_sel;
    logic            w_valid;
    logic            w_forced;
    logic            w_pause;
    logic [HIPROC:0] w_grant_vec;
    logic [HIPROC:0] w_fair;
    logic [CNTW-1:0] w_wait_d  [NPROC];
    logic [CNTW-1:0] w_pause_d [NPROC];

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NPROC; i++) begin
            w_starved[i] = bus.req[i] && (r_wait_cnt[i] == CNT_BOUND);
        end
    end

    // Pointer HIPROC makes the scan start at 0, so the lowest starved index wins.
    bakery_rr_pick #(.SELMSB(SELMSB), .HIPROC(HIPROC)) u_starve_pick (
        .i_req   (bus.req),
        .i_ptr   (LOW_PTR),
        .i_mask  (w_starved),
        .o_idx   (w_st_idx),
        .o_valid (w_st_valid)
    );

    bakery_rr_pick #(.SELMSB(SELMSB), .HIPROC(HIPROC)) u_rr_pick (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .i_mask  ({(HIPROC + 1){1'b1}}),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    always_comb begin
        // Out-of-range choice matches no index and falls through to round-robin.
        w_choice_ok = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            if (int'(bus.choice) == i) begin
                w_choice_ok = bus.req[i];
            end
        end

        w_forced = w_st_valid;
        w_valid  = w_st_valid | w_choice_ok | w_rr_valid;
        if (w_st_valid) begin
            w_sel = w_st_idx;
        end else if (w_choice_ok) begin
            w_sel = bus.choice;
        end else begin
            w_sel = w_rr_idx;
        end

        w_grant_vec = '0;
        w_pause     = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            w_grant_vec[i] = w_valid && (w_sel == SELW'(i));
            if (w_grant_vec[i]) begin
                w_pause = bus.want_pause && (r_pause_cnt[i] < CNT_PMAX) && !w_forced;
            end
        end

        w_fair = w_grant_vec & {(HIPROC + 1){~w_pause}};

        for (int i = 0; i < NPROC; i++) begin
            if (!bus.req[i] || (w_grant_vec[i] && !w_pause)) begin
                w_wait_d[i] = '0;
            end else if (r_wait_cnt[i] == CNT_BOUND) begin
                w_wait_d[i] = r_wait_cnt[i];
            end else begin
                w_wait_d[i] = r_wait_cnt[i] + 1'b1;
            end

            if (w_grant_vec[i]) begin
                w_pause_d[i] = w_pause ? r_pause_cnt[i] + 1'b1 : '0;
            end else begin
                w_pause_d[i] = r_pause_cnt[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_select      <= '0;
            r_pause       <= 1'b0;
            r_grant_valid <= 1'b0;
            r_forced      <= 1'b0;
            r_fair        <= '0;
            for (int i = 0; i < NPROC; i++) begin
                r_wait_cnt[i]  <= '0;
                r_pause_cnt[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state       <= S_FREE;
                    r_select      <= '0;
                    r_pause       <= 1'b0;
                    r_grant_valid <= 1'b0;
                    r_forced      <= 1'b0;
                    r_fair        <= '0;
                end
                S_FREE, S_FORCE: begin
                    r_state       <= w_st_valid ? S_FORCE : S_FREE;
                    r_select      <= w_sel;
                    r_pause       <= w_pause;
                    r_grant_valid <= w_valid;
                    r_forced      <= w_forced;
                    r_fair        <= w_fair;
                    if (w_valid) begin
                        r_rr_ptr <= w_sel;
                    end
                    for (int i = 0; i < NPROC; i++) begin
                        r_wait_cnt[i]  <= w_wait_d[i];
                        r_pause_cnt[i] <= w_pause_d[i];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.select      = r_select;
    assign bus.pause       = r_pause;
    assign bus.grant_valid = r_grant_valid;
    assign bus.forced      = r_forced;
    assign bus.fair        = r_fair;
endmodule

// File: tb/tb_bakery_fair_sched.sv
// Bench for bakery_fair_sched: directed scenarios plus a randomized run against
// an arithmetic model of the grant rules.
module tb_bakery_fair_sched;
    localparam int NPROC     = 3;
    localparam int BOUND     = 3;
    localparam int PAUSE_MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bakery_fair_sched_if #(.SELMSB(1), .HIPROC(2)) bus ();

    bakery_fair_sched #(
        .SELMSB(1), .HIPROC(2), .BOUND(3), .PAUSE_MAX(2), .CNTW(2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_wait [NPROC];
    int m_pcnt [NPROC];
    int m_rr;
    bit m_idle;

    // {grant_valid, select[1:0], pause, forced, fair[2:0]}
    function automatic logic [7:0] outs();
        return {bus.grant_valid, bus.select, bus.pause, bus.forced, bus.fair};
    endfunction

    function automatic logic [7:0] grant(input int sel, input bit ps, input bit frc);
        logic [2:0] f;
        logic [1:0] s;
        f = '0;
        if (!ps) f[sel] = 1'b1;
        s = 2'(sel);
        return {1'b1, s, ps, frc, f};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_in(input logic [2:0] r, input logic [1:0] c, input logic wp);
        bus.req        = r;
        bus.choice     = c;
        bus.want_pause = wp;
    endtask

    task automatic model_step(input bit r, input logic [2:0] rq, input int ch, input bit wp,
                              output logic [7:0] exp);
        int sel;
        int j;
        bit frc;
        bit ps;
        exp = '0;
        if (r) begin
            m_idle = 1'b1;
            m_rr   = 0;
            for (int i = 0; i < NPROC; i++) begin
                m_wait[i] = 0;
                m_pcnt[i] = 0;
            end
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            sel = -1;
            frc = 1'b0;
            for (int i = 0; i < NPROC; i++) begin
                if (sel < 0 && rq[i] && m_wait[i] == BOUND) begin
                    sel = i;
                    frc = 1'b1;
                end
            end
            if (sel < 0 && ch < NPROC) begin
                if (rq[ch]) sel = ch;
            end
            for (int k = 1; k <= NPROC; k++) begin
                j = (m_rr + k) % NPROC;
                if (sel < 0 && rq[j]) sel = j;
            end
            if (sel < 0) begin
                for (int i = 0; i < NPROC; i++) m_wait[i] = 0;
            end else begin
                ps = wp && (m_pcnt[sel] < PAUSE_MAX) && !frc;
                for (int i = 0; i < NPROC; i++) begin
                    if (!rq[i] || (i == sel && !ps)) m_wait[i] = 0;
                    else if (m_wait[i] < BOUND) m_wait[i] = m_wait[i] + 1;
                end
                m_pcnt[sel] = ps ? m_pcnt[sel] + 1 : 0;
                m_rr = sel;
                exp = grant(sel, ps, frc);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        set_in(3'b111, 2'd0, 1'b0);
        rst = 1'b1;
        tick();
        n_checks++;
        if (outs() !== 8'h00) $display("FAIL reset_outputs: got %b want %b", outs(), 8'h00);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (outs() !== 8'h00) $display("FAIL idle_cycle: got %b want %b", outs(), 8'h00);
        else n_pass++;
        tick();
        exp = grant(0, 1'b0, 1'b0);
        n_checks++;
        if (outs() !== exp) $display("FAIL first_grant: got %b want %b", outs(), exp);
        else n_pass++;
    endtask

    task automatic test_starvation();
        int sels [6] = '{0, 0, 0, 1, 2, 0};
        bit frcs [6] = '{0, 0, 0, 1, 1, 0};
        logic [7:0] exp;
        do_reset();
        set_in(3'b111, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = grant(sels[i], 1'b0, frcs[i]);
            n_checks++;
            if (outs() !== exp) $display("FAIL starve[%0d]: got %b want %b", i, outs(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] exp;
        do_reset();
        set_in(3'b010, 2'd3, 1'b0);
        exp = grant(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (outs() !== exp) $display("FAIL choice_oob[%0d]: got %b want %b", i, outs(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        logic [7:0] exp;
        do_reset();
        set_in(3'b001, 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = grant(0, (i % 3) != 2, 1'b0);
            n_checks++;
            if (outs() !== exp) $display("FAIL pause[%0d]: got %b want %b", i, outs(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_no_request();
        logic [7:0] exp;
        do_reset();
        set_in(3'b000, 2'd0, 1'b0);
        tick();
        n_checks++;
        if (outs() !== 8'h00) $display("FAIL no_req: got %b want %b", outs(), 8'h00);
        else n_pass++;
        set_in(3'b100, 2'd0, 1'b0);
        tick();
        exp = grant(2, 1'b0, 1'b0);
        n_checks++;
        if (outs() !== exp) $display("FAIL req_after_idle: got %b want %b", outs(), exp);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        do_reset();
        set_in(3'b101, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = grant((i % 2 == 0) ? 2 : 0, 1'b0, 1'b0);
            n_checks++;
            if (outs() !== exp) $display("FAIL rr[%0d]: got %b want %b", i, outs(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp;
        do_reset();
        set_in(3'b111, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        exp = grant(1, 1'b0, 1'b1);
        n_checks++;
        if (outs() !== exp) $display("FAIL pre_reset_forced: got %b want %b", outs(), exp);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if (outs() !== 8'h00) $display("FAIL mid_reset: got %b want %b", outs(), 8'h00);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (outs() !== 8'h00) $display("FAIL mid_reset_idle: got %b want %b", outs(), 8'h00);
        else n_pass++;
        tick();
        exp = grant(0, 1'b0, 1'b0);
        n_checks++;
        if (outs() !== exp) $display("FAIL resume_free: got %b want %b", outs(), exp);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] exp;
        logic [2:0] rq;
        int         ch;
        bit         wp;
        bit         r;
        ch = 0;
        for (int k = 0; k < 400; k++) begin
            r  = (k == 0) || ($urandom_range(0, 39) == 0);
            rq = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ch = $urandom_range(0, 3);
            wp = 1'($urandom_range(0, 1));
            rst = r;
            set_in(rq, 2'(ch), wp);
            tick();
            model_step(r, rq, ch, wp, exp);
            n_checks++;
            if (outs() !== exp) begin
                $display("FAIL random[%0d] req=%b choice=%0d wp=%0d: got %b want %b",
                         k, rq, ch, wp, outs(), exp);
            end else begin
                n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_starvation();
        test_out_of_range();
        test_pause();
        test_no_request();
        test_round_robin();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
